// File: rtl/delay_pkg.sv
// Shared types and defaults for the delay generator and its monitor.
package delay_pkg;

   localparam int DEF_N     = 7500;
   localparam int DEF_CBITS = 13;

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      LOCKED
   } state_t;

   function automatic logic [7:0] sat8_inc(input logic [7:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/delay_gap_counter.sv
// Cycles since the last sig pulse; restarts at 1 after a pulse, saturates.
module delay_gap_counter
   import delay_pkg::*;
#(
   parameter int CBITS = DEF_CBITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig,
   output logic [CBITS-1:0] cur
);

   localparam logic [CBITS-1:0] ONE = {{(CBITS-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         cur <= '0;
      end else if (sig) begin
         cur <= ONE;
      end else if (!(&cur)) begin
         cur <= cur + ONE;
      end
   end

endmodule

// File: rtl/delay_monitor.sv
// Pulse spacing monitor: lock / early / late detection on a delay stream.
// Define DELAY_MON_STATS_EN to build the saturating fault counter.
module delay_monitor
   import delay_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int CBITS    = DEF_CBITS,
   parameter int TOL      = 0,
   parameter int LOCK_CNT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig,
   output logic             lock,
   output logic             err_early,
   output logic             err_late,
   output logic [CBITS-1:0] gap,
   output logic [7:0]       fault_cnt
);

   localparam int P  = N + 1;
   localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

   localparam logic [CBITS-1:0] LO     = CBITS'(P - TOL);
   localparam logic [CBITS-1:0] HI     = CBITS'(P + TOL);
   localparam logic [GW-1:0]    LOCK_G = GW'(LOCK_CNT);
   localparam logic [GW-1:0]    G_ONE  = GW'(1);

   state_t           state;
   logic [CBITS-1:0] cur;
   logic [GW-1:0]    good;
   logic [GW-1:0]    good_nx;
   logic             track;
   logic             early_ev;
   logic             good_ev;
   logic             late_ev;

   delay_gap_counter #(
      .CBITS(CBITS)
   ) u_gap (
      .clk(clk),
      .rst(rst),
      .sig(sig),
      .cur(cur)
   );

   always_comb begin
      track    = (state != SEARCH);
      early_ev = track && sig && (cur < LO);
      good_ev  = track && sig && !early_ev && (cur <= HI);
      // a pulse beyond HI cannot occur: late fires at HI first
      late_ev  = track && !early_ev && !good_ev && (cur >= HI);
      good_nx  = (good == LOCK_G) ? good : good + G_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEARCH;
         good      <= '0;
         lock      <= 1'b0;
         err_early <= 1'b0;
         err_late  <= 1'b0;
         gap       <= '0;
      end else begin
         err_early <= 1'b0;
         err_late  <= 1'b0;
         unique case (1'b1)
            (!track && sig): begin
               state <= MEASURE;
               good  <= '0;
            end
            early_ev: begin
               state     <= MEASURE;
               good      <= '0;
               gap       <= cur;
               lock      <= 1'b0;
               err_early <= 1'b1;
            end
            good_ev: begin
               good <= good_nx;
               gap  <= cur;
               if (good_nx == LOCK_G) begin
                  state <= LOCKED;
                  lock  <= 1'b1;
               end
            end
            late_ev: begin
               state    <= SEARCH;
               good     <= '0;
               lock     <= 1'b0;
               err_late <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef DELAY_MON_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_cnt <= '0;
      end else if (early_ev || late_ev) begin
         fault_cnt <= sat8_inc(fault_cnt);
      end
   end
`else
   assign fault_cnt = 8'd0;
`endif

endmodule

// File: doc/delay_monitor.md
DELAY_MONITOR -- requirements
Module: delay_monitor

Interface
REQ-001 Parameter N, default 7500, generator terminal count; expected pulse spacing P = N+1 cycles.
REQ-002 Parameter CBITS, default 13, gap counter width; SHALL hold P+TOL.
REQ-003 Parameter TOL, default 0, allowed spacing deviation (cycles, either side).
REQ-004 Parameter LOCK_CNT, default 2, consecutive in-window intervals needed for lock.
REQ-005 clk  input  1  single clock, all logic on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 sig  input  1  pulse stream from the delay generator; each high cycle counts as one pulse.
REQ-008 lock  output  1  spacing verified, high while in LOCKED.
REQ-009 err_early  output  1  one-cycle strobe: pulse arrived with gap < P-TOL.
REQ-010 err_late  output  1  one-cycle strobe: no pulse by gap == P+TOL.
REQ-011 gap  output  CBITS  last measured pulse interval.
REQ-012 fault_cnt  output  8  saturating fault count (see Configuration).

Function
REQ-013 Internal counter cur SHALL load 1 on the cycle after a pulse, else increment, saturating at all-ones; cur at a pulse cycle = interval since previous pulse.
REQ-014 States SEARCH, MEASURE, LOCKED; SEARCH after reset.
REQ-015 SEARCH: pulse -> MEASURE, good count cleared; no error strobes.
REQ-016 MEASURE/LOCKED: pulse with P-TOL <= cur <= P+TOL is good; gap <= cur; good count increments, saturating at LOCK_CNT.
REQ-017 MEASURE: good count reaching LOCK_CNT -> LOCKED.
REQ-018 MEASURE/LOCKED: pulse with cur < P-TOL -> err_early, gap <= cur, good count 0, state MEASURE (pulse becomes new reference).
REQ-019 MEASURE/LOCKED: cur == P+TOL and sig low -> err_late, good count 0, state SEARCH.
REQ-020 sig high on consecutive cycles SHALL count as separate pulses (second yields cur=1, early when P-TOL > 1).
REQ-021 All outputs registered; strobes and lock change exactly one cycle after the deciding sig cycle.
REQ-022 err_early and err_late SHALL never assert in the same cycle.
REQ-023 TOL >= P is illegal; behaviour undefined.

Reset
REQ-024 rst SHALL dominate sig in the same cycle.
REQ-025 On rst: state SEARCH, cur 0, good count 0, lock 0, err_early 0, err_late 0, gap 0, fault_cnt 0.
REQ-026 Reset mid-interval discards the partial measurement; next pulse is treated as first.

Configuration
REQ-027 Macro DELAY_MON_STATS_EN: when defined, fault_cnt increments on every err_early or err_late, saturating at 255.
REQ-028 Without DELAY_MON_STATS_EN, fault_cnt SHALL be constant 0 and its counter not synthesised; all other behaviour identical.

Structure
REQ-029 Shared package delay_pkg SHALL hold the state enum (SEARCH, MEASURE, LOCKED) and the default N/CBITS constants common to generator and monitor.
REQ-030 Gap counter (REQ-013) SHALL be a sub-module delay_gap_counter; FSM, window compare and stats in delay_monitor.

Verification (N=10 -> P=11, TOL=1, LOCK_CNT=2)
REQ-031 Pulses every 11 cycles after reset -> lock rises 1 cycle after the 3rd pulse; gap=11; no error strobes.
REQ-032 Locked, next pulse after 8 cycles -> err_early one cycle, lock 0, gap=8; two further 11-cycle pulses relock.
REQ-033 Locked, sig held low -> err_late exactly one cycle after the cycle where cur=12, lock 0, state SEARCH.
REQ-034 Spacing 10 and 12 alternating -> all good, lock held; spacing 13 -> err_late at cur=12.
REQ-035 rst asserted with sig high mid-lock -> all outputs 0 next cycle; next pulse only re-arms (no strobe).
REQ-036 With DELAY_MON_STATS_EN, 300 early pulses -> fault_cnt saturates at 255; without it fault_cnt stays 0.
